// File: rtl/reg_file_mp_if.sv
// Read/write bus of the multi-port register file; the core side is the master,
// the register file the slave.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
);
    localparam int IDX_W = $clog2(REG_NUM);

    logic [READ_PORTS*IDX_W-1:0]       rd_num;
    logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data;
    logic [WRITE_PORTS-1:0]            wr_en;
    logic [WRITE_PORTS*IDX_W-1:0]      wr_num;
    logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data;
    logic                              init_busy;
    logic                              wr_collision;

    modport master (
        output rd_num, wr_en, wr_num, wr_data,
        input  rd_data, init_busy, wr_collision
    );

    modport slave (
        input  rd_num, wr_en, wr_num, wr_data,
        output rd_data, init_busy, wr_collision
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: combinational reads, prioritised synchronous writes,
// optional zero register and write bypass, hardware clear sweep after reset.
module reg_file_mp #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit BYPASS      = 1'b1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    localparam int               IDX_W    = $clog2(REG_NUM);
    localparam logic [IDX_W:0]   DEPTH    = (IDX_W+1)'(REG_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_NUM - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sweepCnt_q, sweepCnt_d;
    logic                    collision_q, collision_d;
    logic [DATA_WIDTH-1:0]   mem_q [REG_NUM];

    logic [IDX_W-1:0]        wrIdx [WRITE_PORTS];
    logic [DATA_WIDTH-1:0]   wrDat [WRITE_PORTS];
    logic [WRITE_PORTS-1:0]  wrValid;
    logic                    running;

    assign running = (state_q == RUN);

    // A write is valid only in RUN, in range, and not aimed at a hard-wired zero register.
    always_comb begin
        wrValid = '0;
        for (int j = 0; j < WRITE_PORTS; j++) begin
            wrIdx[j]   = bus.wr_num[j*IDX_W +: IDX_W];
            wrDat[j]   = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            wrValid[j] = running && bus.wr_en[j]
                         && ({1'b0, wrIdx[j]} < DEPTH)
                         && !(ZERO_REG && (wrIdx[j] == '0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            sweepCnt_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweepCnt_q  <= sweepCnt_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        case (state_q)
            INIT: begin
                if (sweepCnt_q == LAST_IDX) begin
                    state_d    = RUN;
                    sweepCnt_d = '0;
                end else begin
                    sweepCnt_d = sweepCnt_q + 1'b1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        collision_d = 1'b0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (wrValid[i] && wrValid[j] && (wrIdx[i] == wrIdx[j])) begin
                    collision_d = 1'b1;
                end
            end
        end
    end

    assign bus.init_busy    = (state_q == INIT);
    assign bus.wr_collision = collision_q;

    // Later ports are written last, so the highest enabled port wins a same-index conflict.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[sweepCnt_q] <= '0;
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wrValid[j]) begin
                    mem_q[wrIdx[j]] <= wrDat[j];
                end
            end
        end
    end

    always_comb begin
        logic [IDX_W-1:0]      rdIdx;
        logic [DATA_WIDTH-1:0] rdVal;
        bus.rd_data = '0;
        rdIdx       = '0;
        rdVal       = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            rdIdx = bus.rd_num[k*IDX_W +: IDX_W];
            rdVal = '0;
            if (running && ({1'b0, rdIdx} < DEPTH) && !(ZERO_REG && (rdIdx == '0))) begin
                rdVal = mem_q[rdIdx];
                if (BYPASS) begin
                    for (int j = 0; j < WRITE_PORTS; j++) begin
                        if (wrValid[j] && (wrIdx[j] == rdIdx)) begin
                            rdVal = wrDat[j];
                        end
                    end
                end
            end
            bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rdVal;
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Drives three register-file variants with identical stimulus and checks them against
// a bench-side reference model through a scoreboard queue.
module tb_reg_file_mp;
    logic        clk;
    logic        rst;
    logic [19:0] rdNum;
    logic [1:0]  wrEn;
    logic [9:0]  wrNum;
    logic [63:0] wrData;

    reg_file_mp_if #(.DATA_WIDTH(32), .REG_NUM(32), .READ_PORTS(4), .WRITE_PORTS(2)) ifA ();
    reg_file_mp_if #(.DATA_WIDTH(32), .REG_NUM(32), .READ_PORTS(4), .WRITE_PORTS(2)) ifB ();
    reg_file_mp_if #(.DATA_WIDTH(32), .REG_NUM(24), .READ_PORTS(4), .WRITE_PORTS(2)) ifC ();

    assign ifA.rd_num = rdNum;  assign ifA.wr_en = wrEn;  assign ifA.wr_num = wrNum;  assign ifA.wr_data = wrData;
    assign ifB.rd_num = rdNum;  assign ifB.wr_en = wrEn;  assign ifB.wr_num = wrNum;  assign ifB.wr_data = wrData;
    assign ifC.rd_num = rdNum;  assign ifC.wr_en = wrEn;  assign ifC.wr_num = wrNum;  assign ifC.wr_data = wrData;

    reg_file_mp #(.DATA_WIDTH(32), .REG_NUM(32), .READ_PORTS(4), .WRITE_PORTS(2),
                  .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    reg_file_mp #(.DATA_WIDTH(32), .REG_NUM(32), .READ_PORTS(4), .WRITE_PORTS(2),
                  .ZERO_REG(1'b1), .BYPASS(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB));
    reg_file_mp #(.DATA_WIDTH(32), .REG_NUM(24), .READ_PORTS(4), .WRITE_PORTS(2),
                  .ZERO_REG(1'b0), .BYPASS(1'b1)) dutC (.clk(clk), .rst(rst), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cfg;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } sbEntry_t;

    typedef struct {
        string       name;
        logic [1:0]  en;
        logic [9:0]  wn;
        logic [63:0] wd;
        logic [19:0] rn;
        logic [31:0] handA;
        logic [31:0] handB;
    } vec_t;

    sbEntry_t    sbQ [$];
    int          compared   = 0;
    int          mismatched = 0;

    int          regNumCfg [3] = '{32, 32, 24};
    bit          zeroCfg   [3] = '{1'b1, 1'b1, 1'b0};
    bit          bypCfg    [3] = '{1'b1, 1'b0, 1'b1};
    int          sweepLeft [3];
    logic        collExp   [3];
    logic [31:0] mdl       [3][32];

    function automatic logic [19:0] rd4(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [9:0] wn2(input int p0, input int p1);
        return {5'(p1), 5'(p0)};
    endfunction

    function automatic bit wrOk(input int c, input int j);
        int idx;
        idx = int'(wrNum[j*5 +: 5]);
        return wrEn[j] && (idx < regNumCfg[c]) && !(zeroCfg[c] && idx == 0);
    endfunction

    function automatic logic [31:0] expRead(input int c, input int k);
        int          idx;
        logic [31:0] v;
        idx = int'(rdNum[k*5 +: 5]);
        if (rst || sweepLeft[c] != 0) return 32'h0;
        if (idx >= regNumCfg[c]) return 32'h0;
        if (zeroCfg[c] && idx == 0) return 32'h0;
        v = mdl[c][idx];
        if (bypCfg[c]) begin
            for (int j = 0; j < 2; j++) begin
                if (wrOk(c, j) && int'(wrNum[j*5 +: 5]) == idx) v = wrData[j*32 +: 32];
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] getActual(input int c, input int kind);
        logic [127:0] rd;
        logic         b;
        logic         co;
        case (c)
            0:       begin rd = ifA.rd_data; b = ifA.init_busy; co = ifA.wr_collision; end
            1:       begin rd = ifB.rd_data; b = ifB.init_busy; co = ifB.wr_collision; end
            default: begin rd = ifC.rd_data; b = ifC.init_busy; co = ifC.wr_collision; end
        endcase
        if (kind < 4) return rd[kind*32 +: 32];
        if (kind == 4) return {31'b0, b};
        return {31'b0, co};
    endfunction

    function automatic void pushExp(input int c, input int kind, input logic [31:0] v, input string tag);
        sbEntry_t e;
        e.cfg  = c;
        e.kind = kind;
        e.exp  = v;
        e.tag  = tag;
        sbQ.push_back(e);
    endfunction

    // Model advances on the same edge as the DUTs, using the inputs held across it.
    task automatic updateModel();
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                collExp[c] = 1'b0;
            end else if (sweepLeft[c] != 0) begin
                sweepLeft[c]--;
                collExp[c] = 1'b0;
                if (sweepLeft[c] == 0) begin
                    for (int r = 0; r < 32; r++) mdl[c][r] = 32'h0;
                end
            end else begin
                collExp[c] = wrOk(c, 0) && wrOk(c, 1) && (wrNum[4:0] == wrNum[9:5]);
                for (int j = 0; j < 2; j++) begin
                    if (wrOk(c, j)) mdl[c][int'(wrNum[j*5 +: 5])] = wrData[j*32 +: 32];
                end
            end
        end
    endtask

    task automatic checkOutput();
        sbEntry_t    e;
        logic [31:0] act;
        while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            act = getActual(e.cfg, e.kind);
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("[TB] FAIL %s cfg%0d kind%0d: got %h expected %h",
                         e.tag, e.cfg, e.kind, act, e.exp);
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic rstV, input logic [1:0] en,
                                 input logic [9:0] wn, input logic [63:0] wd, input logic [19:0] rn,
                                 input logic useHand, input logic [31:0] handA, input logic [31:0] handB);
        @(negedge clk);
        rst    = rstV;
        wrEn   = en;
        wrNum  = wn;
        wrData = wd;
        rdNum  = rn;
        if (rstV) begin
            for (int c = 0; c < 3; c++) begin
                sweepLeft[c] = regNumCfg[c];
                collExp[c]   = 1'b0;
            end
        end
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) pushExp(c, k, expRead(c, k), {name, "_rd"});
            pushExp(c, 4, {31'b0, (rstV || sweepLeft[c] != 0)}, {name, "_busy"});
            pushExp(c, 5, {31'b0, collExp[c]}, {name, "_coll"});
        end
        if (useHand) begin
            pushExp(0, 0, handA, {name, "_handA"});
            pushExp(1, 0, handB, {name, "_handB"});
        end
        #1 checkOutput();
        @(posedge clk);
        updateModel();
    endtask

    task automatic idle(input string name, input logic rstV, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(name, rstV, 2'b00, '0, '0, rd4(1, 2, 3, 4), 1'b0, '0, '0);
    endtask

    task automatic readAllZero(input string name);
        for (int i = 0; i < 32; i += 4) applyStimulus(name, 1'b0, 2'b00, '0, '0, rd4(i, i+1, i+2, i+3), 1'b1, '0, '0);
    endtask

    vec_t vecs [10];

    initial begin
        rst    = 1'b1;
        wrEn   = '0;
        wrNum  = '0;
        wrData = '0;
        rdNum  = '0;
        for (int c = 0; c < 3; c++) begin
            sweepLeft[c] = regNumCfg[c];
            collExp[c]   = 1'b0;
            for (int r = 0; r < 32; r++) mdl[c][r] = 32'h0;
        end

        vecs[0] = '{"bypass_r5",   2'b01, wn2(5, 0),  {32'h0, 32'h12345678},       rd4(5, 5, 0, 1),   32'h12345678, 32'h0};
        vecs[1] = '{"after_r5",    2'b00, wn2(0, 0),  64'h0,                       rd4(5, 1, 2, 5),   32'h12345678, 32'h12345678};
        vecs[2] = '{"zero_r0",     2'b01, wn2(0, 0),  {32'h0, 32'hFFFFFFFF},       rd4(0, 5, 0, 0),   32'h0,        32'h0};
        vecs[3] = '{"zero_r0_x2",  2'b11, wn2(0, 0),  {32'h1, 32'hFFFFFFFF},       rd4(0, 0, 5, 0),   32'h0,        32'h0};
        vecs[4] = '{"conflict_r7", 2'b11, wn2(7, 7),  {32'h5555, 32'hAAAA},        rd4(7, 0, 7, 5),   32'h5555,     32'h0};
        vecs[5] = '{"after_r7",    2'b00, wn2(0, 0),  64'h0,                       rd4(7, 0, 5, 7),   32'h5555,     32'h5555};
        vecs[6] = '{"idle_r7",     2'b00, wn2(0, 0),  64'h0,                       rd4(7, 7, 7, 7),   32'h5555,     32'h5555};
        vecs[7] = '{"split_9_10",  2'b11, wn2(10, 9), {32'h0909, 32'h0A0A},        rd4(9, 10, 7, 5),  32'h0909,     32'h0};
        vecs[8] = '{"range_r28",   2'b01, wn2(28, 0), {32'h0, 32'hCAFE},           rd4(28, 9, 10, 0), 32'hCAFE,     32'h0};
        vecs[9] = '{"after_r28",   2'b00, wn2(0, 0),  64'h0,                       rd4(28, 10, 9, 0), 32'hCAFE,     32'hCAFE};

        // Reset with a user write held on throughout: it must never land.
        for (int i = 0; i < 3; i++)
            applyStimulus("reset", 1'b1, 2'b01, wn2(3, 0), {32'h0, 32'hDEAD}, rd4(3, 0, 1, 2), 1'b0, '0, '0);
        for (int i = 0; i < 20; i++)
            applyStimulus("sweep", 1'b0, 2'b01, wn2(3, 0), {32'h0, 32'hDEAD}, rd4(3, 0, 1, 2), 1'b0, '0, '0);
        idle("sweep_end", 1'b0, 16);
        readAllZero("post_reset");

        for (int v = 0; v < 10; v++)
            applyStimulus(vecs[v].name, 1'b0, vecs[v].en, vecs[v].wn, vecs[v].wd, vecs[v].rn,
                          1'b1, vecs[v].handA, vecs[v].handB);

        for (int i = 1; i <= 31; i += 2)
            applyStimulus("mp_write", 1'b0, (i < 31) ? 2'b11 : 2'b01, wn2(i, (i < 31) ? i + 1 : 0),
                          {32'h100 + 32'(i + 1), 32'h100 + 32'(i)}, rd4(i, i + 1, 0, 7), 1'b0, '0, '0);
        for (int i = 1; i <= 31; i += 4)
            applyStimulus("mp_read", 1'b0, 2'b00, '0, '0,
                          rd4(i, ((i) % 31) + 1, ((i + 1) % 31) + 1, ((i + 2) % 31) + 1),
                          1'b1, 32'h100 + 32'(i), 32'h100 + 32'(i));

        // Reset landing mid-sweep must restart the full clear from entry 0.
        idle("re_reset", 1'b1, 3);
        idle("part_sweep", 1'b0, 10);
        idle("mid_reset", 1'b1, 2);
        idle("full_sweep", 1'b0, 36);
        readAllZero("post_mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
